onehot_rr_scheduler: RTL and testbench

//  Upstream stage of the 8-to-3 priority/one-hot encoder. Latches 8 event-request

---
 rtl/onehot_rr_scheduler.sv | 101 ++++++++++
 tb/tb_onehot_rr_scheduler.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/onehot_rr_scheduler.sv
// onehot_rr_scheduler
// Front end of the 8-to-3 encoder path. Request pulses are accumulated into a
// pending mask. One pending request at a time is issued as a registered one-hot
// grant, chosen round-robin starting at a rotating pointer.
//
// Handshake: grant/grant_valid follow valid/ready rules. While grant_valid is
// high, grant stays stable until a rising edge that sees out_ready high, and that
// edge is where the transfer happens. At that same edge the next pending request
// (if any) is issued, so a consumer holding out_ready high can take one grant per
// cycle. out_ready has no effect while grant_valid is low.
module onehot_rr_scheduler #(
  parameter int N     = 8,
  parameter int PTR_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             out_ready,
  output logic [N-1:0]     grant,
  output logic             grant_valid,
  output logic [N-1:0]     pending,
  output logic             overflow,
  output logic             state_dbg,
  output logic [PTR_W-1:0] ptr_dbg
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic [N-1:0]     pending_q;
  logic [N-1:0]     grant_q;
  logic             grant_valid_q;
  logic             overflow_q;

  logic             sel_found;
  logic [PTR_W-1:0] sel_idx;
  logic [N-1:0]     sel_onehot;
  logic [PTR_W-1:0] ptr_next;
  logic             issue;
  logic [N-1:0]     issue_mask;

  // Round-robin pick: first registered pending bit at or after ptr, with wrap.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!sel_found && pending_q[(int'(ptr) + k) % N]) begin
        sel_found = 1'b1;
        sel_idx   = PTR_W'((int'(ptr) + k) % N);
      end
    end
  end

  // Issue decision and the derived one-hot, pointer advance and clear mask.
  always_comb begin
    sel_onehot = {{(N-1){1'b0}}, 1'b1} << sel_idx;
    ptr_next   = PTR_W'((int'(sel_idx) + 1) % N);
    // A new grant goes out when idle, or when the held grant is being accepted.
    issue      = sel_found && ((state == IDLE) || out_ready);
    issue_mask = issue ? sel_onehot : '0;
  end

  // Scheduler state: pending mask, overflow pulse, and the IDLE/GRANT FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      pending_q     <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      // A request landing on a bit that is still pending is merged; flag it.
      // The bit issued at this edge is not pending any more, so no loss there.
      pending_q  <= (pending_q & ~issue_mask) | req;
      overflow_q <= |(req & pending_q & ~issue_mask);
      if (issue) begin
        grant_q       <= sel_onehot;
        grant_valid_q <= 1'b1;
        ptr           <= ptr_next;
        state         <= GRANT;
      end else if ((state == GRANT) && out_ready) begin
        grant_q       <= '0;
        grant_valid_q <= 1'b0;
        state         <= IDLE;
      end
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign pending     = pending_q;
  assign overflow    = overflow_q;
  assign state_dbg   = state;
  assign ptr_dbg     = ptr;

endmodule

// File: tb/tb_onehot_rr_scheduler.sv
// Directed bench for onehot_rr_scheduler. Grants expected to be accepted are
// queued when the stimulus is driven; a negedge monitor pops them on each
// accepted transfer and also checks the one-hot / zero-when-idle invariants.
module tb_onehot_rr_scheduler;

  localparam int N = 8;
  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic         out_ready;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [N-1:0] pending;
  logic         overflow;
  logic         state_dbg;
  logic [2:0]   ptr_dbg;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  onehot_rr_scheduler #(.N(N), .PTR_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .out_ready   (out_ready),
    .grant       (grant),
    .grant_valid (grant_valid),
    .pending     (pending),
    .overflow    (overflow),
    .state_dbg   (state_dbg),
    .ptr_dbg     (ptr_dbg)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: advance n rising edges, land 1 time unit after the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    cyc(1);
    rst = 1'b0;
  endtask

  // Scoreboard monitor: a transfer happens at the next edge when valid && ready.
  always @(negedge clk) begin
    if (!rst) begin
      if (grant_valid)
        check("inv_onehot", 32'($onehot(grant)), 32'd1);
      else
        check("inv_zero", 32'(grant), 32'd0);
      if (grant_valid && out_ready) begin
        if (exp_q.size() == 0)
          check("sb_unexpected", 32'(grant), 32'hFFFF_FFFF);
        else
          check("sb_grant", 32'(grant), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [N-1:0] prev;
    logic [N-1:0] want;
    rst = 1'b1;
    req = 8'hFF;
    out_ready = 1'b0;

    // 1: reset dominates a full request vector
    cyc(2);
    check("t1_grant", 32'(grant), 32'h00);
    check("t1_valid", 32'(grant_valid), 32'd0);
    check("t1_pending", 32'(pending), 32'h00);
    check("t1_overflow", 32'(overflow), 32'd0);
    check("t1_ptr", 32'(ptr_dbg), 32'd0);

    // 2: single request, held for 5 cycles, then accepted
    rst = 1'b0;
    req = 8'h04;
    cyc(1);
    req = 8'h00;
    check("t2_pending", 32'(pending), 32'h04);
    check("t2_valid_early", 32'(grant_valid), 32'd0);
    cyc(1);
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_valid", 32'(grant_valid), 32'd1);
      check("t2_hold_grant", 32'(grant), 32'h04);
      check("t2_hold_state", 32'(state_dbg), 32'd1);
      if (i < 4) cyc(1);
    end
    exp_q.push_back(8'h04);
    out_ready = 1'b1;
    cyc(1);
    check("t2_valid_after", 32'(grant_valid), 32'd0);
    check("t2_grant_after", 32'(grant), 32'h00);
    check("t2_ptr", 32'(ptr_dbg), 32'd3);
    out_ready = 1'b0;

    // 3: wrap-around pair from ptr=0, back-to-back
    do_reset();
    check("t3_ptr_start", 32'(ptr_dbg), 32'd0);
    out_ready = 1'b1;
    req = 8'h81;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h80);
    cyc(1);
    req = 8'h00;
    cyc(1);
    check("t3_first", 32'(grant), 32'h01);
    cyc(1);
    check("t3_second", 32'(grant), 32'h80);
    check("t3_second_valid", 32'(grant_valid), 32'd1);
    cyc(1);
    check("t3_idle", 32'(grant_valid), 32'd0);
    check("t3_ptr_end", 32'(ptr_dbg), 32'd0);

    // 4: two persistent requesters alternate
    do_reset();
    out_ready = 1'b1;
    req = 8'h21;
    for (int k = 0; k < 8; k++)
      exp_q.push_back((k % 2 == 0) ? 8'h01 : 8'h20);
    cyc(2);
    prev = 8'h00;
    for (int k = 0; k < 8; k++) begin
      want = (k % 2 == 0) ? 8'h01 : 8'h20;
      check("t4_grant", 32'(grant), 32'(want));
      check("t4_no_repeat", 32'(grant != prev), 32'd1);
      prev = grant;
      if (k == 5) req = 8'h00;
      cyc(1);
    end
    check("t4_idle", 32'(grant_valid), 32'd0);
    check("t4_pending", 32'(pending), 32'h00);

    // 5: duplicate request while blocked behind a held grant
    do_reset();
    out_ready = 1'b0;
    req = 8'h01;
    cyc(1);
    req = 8'h00;
    cyc(1);
    check("t5_held", 32'(grant), 32'h01);
    req = 8'h10;
    cyc(1);
    check("t5_ovf_t1", 32'(overflow), 32'd0);
    check("t5_pending", 32'(pending), 32'h10);
    cyc(1);
    req = 8'h00;
    check("t5_ovf_t2", 32'(overflow), 32'd1);
    cyc(1);
    check("t5_ovf_t3", 32'(overflow), 32'd0);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h10);
    out_ready = 1'b1;
    cyc(1);
    check("t5_second", 32'(grant), 32'h10);
    cyc(1);
    check("t5_idle", 32'(grant_valid), 32'd0);
    check("t5_pending_end", 32'(pending), 32'h00);
    cyc(2);
    check("t5_no_dup", 32'(grant_valid), 32'd0);

    // 6: reset mid-grant drops everything
    do_reset();
    out_ready = 1'b0;
    req = 8'h02;
    cyc(1);
    req = 8'h30;
    cyc(1);
    req = 8'h00;
    check("t6_held", 32'(grant), 32'h02);
    check("t6_pending", 32'(pending), 32'h30);
    rst = 1'b1;
    cyc(1);
    check("t6_rst_grant", 32'(grant), 32'h00);
    check("t6_rst_valid", 32'(grant_valid), 32'd0);
    check("t6_rst_pending", 32'(pending), 32'h00);
    check("t6_rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    cyc(3);
    check("t6_quiet_valid", 32'(grant_valid), 32'd0);
    check("t6_quiet_pending", 32'(pending), 32'h00);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
